// File: rtl/div128by64seq.sv
// div128by64seq: iterative radix-2 restoring divider, 2*WID-bit dividend by
// WID-bit divisor, one quotient bit per clock, valid/ready on both sides.
// Optional macro DIV_SIGNED_EN adds signed (two's complement) requests via sgn
// and a FIX state that restores result signs; without it all ops are unsigned.
module div128by64seq #(
  parameter int WID = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WID-1:0]   a,
  input  logic [WID-1:0]     b,
  input  logic               sgn,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WID-1:0]     q,
  output logic [WID-1:0]     r,
  output logic               dbz,
  output logic               ovf
);

  localparam int CW = $clog2(WID);

`ifdef DIV_SIGNED_EN
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_CHK = 3'd1, S_RUN = 3'd2, S_FIX = 3'd3, S_DONE = 3'd4
  } state_e;
`else
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_CHK = 3'd1, S_RUN = 3'd2, S_DONE = 3'd4
  } state_e;
`endif

  state_e state_q, state_d;

  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;

  // operand capture and iteration state
  logic [2*WID-1:0]   a_q;
  logic [WID-1:0]     b_q;
  logic [WID-1:0]     dvs_q;      // divisor magnitude used by the iterations
  logic [WID:0]       rem_q;      // partial remainder, one guard bit
  logic [WID-1:0]     sr_q;       // dividend low half shifting out, quotient bits shifting in
  logic [CW-1:0]      cnt_q;

  // result registers
  logic [WID-1:0]     q_res_q;
  logic [WID-1:0]     r_res_q;
  logic               dbz_q;
  logic               ovf_q;

  // combinational datapath
  logic [2*WID-1:0]   a_mag_s;
  logic [WID-1:0]     b_mag_s;
  logic               ovf_s;
  logic [WID:0]       shift_s;
  logic [WID+1:0]     trial_s;
  logic               take_s;
  logic [WID:0]       rem_n_s;
  logic [WID-1:0]     sr_n_s;

`ifdef DIV_SIGNED_EN
  logic               sgn_q;
  logic               neg_quo_s;
  logic               neg_rem_s;
  logic [2*WID:0]     lim_pos_s;
  logic [2*WID:0]     lim_neg_s;
`else
  logic               unused_sgn_s;
  assign unused_sgn_s = sgn;
`endif

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign q         = q_res_q;
  assign r         = r_res_q;
  assign dbz       = dbz_q;
  assign ovf       = ovf_q;

  // Operand magnitudes and overflow pre-check; quotient must fit the result width.
  always_comb begin
    a_mag_s = a_q;
    b_mag_s = b_q;
    ovf_s   = (a_q[2*WID-1:WID] >= b_q);
`ifdef DIV_SIGNED_EN
    neg_quo_s = sgn_q & (a_q[2*WID-1] ^ b_q[WID-1]);
    neg_rem_s = sgn_q & a_q[2*WID-1];
    if (sgn_q) begin
      a_mag_s = a_q[2*WID-1] ? -a_q : a_q;
      b_mag_s = b_q[WID-1]   ? -b_q : b_q;
    end else begin
      a_mag_s = a_q;
      b_mag_s = b_q;
    end
    // quotient limit L: overflow iff |a| >= (L+1)*|b|
    lim_pos_s = {2'b00, b_mag_s, {(WID-1){1'b0}}};
    lim_neg_s = lim_pos_s + {{(WID+1){1'b0}}, b_mag_s};
    if (sgn_q) begin
      ovf_s = ({1'b0, a_mag_s} >= (neg_quo_s ? lim_neg_s : lim_pos_s));
    end else begin
      ovf_s = (a_q[2*WID-1:WID] >= b_q);
    end
`endif
  end

  // One restoring step: shift in next dividend bit, subtract divisor if it fits.
  always_comb begin
    shift_s = {rem_q[WID-1:0], sr_q[WID-1]};
    trial_s = {1'b0, shift_s} - {2'b00, dvs_q};
    take_s  = ~trial_s[WID+1];
    rem_n_s = take_s ? trial_s[WID:0] : shift_s;
    sr_n_s  = {sr_q[WID-2:0], take_s};
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_CHK;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CHK: begin
        if (b_q == '0) begin
          state_d = S_DONE;
        end else if (ovf_s) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (cnt_q == '0) begin
`ifdef DIV_SIGNED_EN
          state_d = S_FIX;
`else
          state_d = S_DONE;
`endif
        end else begin
          state_d = S_RUN;
        end
      end
`ifdef DIV_SIGNED_EN
      S_FIX: begin
        state_d = S_DONE;
      end
`endif
      S_DONE: begin
        if (out_valid_q && out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM outputs: ready only in IDLE, valid one cycle after DONE entry until taken.
  always_comb begin
    in_ready_d = (state_d == S_IDLE);
    if (state_q == S_DONE) begin
      out_valid_d = ~(out_valid_q & out_ready);
    end else begin
      out_valid_d = 1'b0;
    end
  end

  // Handshake output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Datapath: operand capture, iteration registers and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      sr_q    <= '0;
      cnt_q   <= '0;
      q_res_q <= '0;
      r_res_q <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef DIV_SIGNED_EN
      sgn_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            a_q <= a;
            b_q <= b;
`ifdef DIV_SIGNED_EN
            sgn_q <= sgn;
`endif
          end
        end
        S_CHK: begin
          if (b_q == '0) begin
            dbz_q   <= 1'b1;
            ovf_q   <= 1'b0;
            q_res_q <= '1;
            r_res_q <= a_q[WID-1:0];
          end else if (ovf_s) begin
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b1;
            q_res_q <= '1;
            r_res_q <= '0;
          end else begin
            dbz_q <= 1'b0;
            ovf_q <= 1'b0;
            dvs_q <= b_mag_s;
            rem_q <= {1'b0, a_mag_s[2*WID-1:WID]};
            sr_q  <= a_mag_s[WID-1:0];
            cnt_q <= CW'(WID - 1);
          end
        end
        S_RUN: begin
          rem_q <= rem_n_s;
          sr_q  <= sr_n_s;
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end
`ifndef DIV_SIGNED_EN
          if (cnt_q == '0) begin
            q_res_q <= sr_n_s;
            r_res_q <= rem_n_s[WID-1:0];
          end
`endif
        end
`ifdef DIV_SIGNED_EN
        S_FIX: begin
          q_res_q <= neg_quo_s ? -sr_q : sr_q;
          r_res_q <= neg_rem_s ? -rem_q[WID-1:0] : rem_q[WID-1:0];
        end
`endif
        S_DONE: begin
          q_res_q <= q_res_q;
          r_res_q <= r_res_q;
        end
        default: begin
          cnt_q <= '0;
        end
      endcase
    end
  end

endmodule
